// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot/periodic reload and terminal-count pulse
module countdown_timer #(
    parameter int WIDTH = 3
) (
    input  logic             Clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] reload_reg, reload_n, count_n;
    logic             done_n;
    // registered state, counter, reload value and done pulse
    always_ff @(posedge Clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload_reg <= reload_n;
            done       <= done_n;
        end
    end
    // next-state: load beats counting; a zero count in RUN either reloads or finishes
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_reg;
        done_n   = 1'b0;
        if (load) begin
            count_n  = load_value;
            reload_n = load_value;
            state_n  = (load_value != '0) ? RUN : IDLE;
        end else if (state == RUN) begin
            if (count == '0 && !auto_reload) begin
                state_n = DONE;
            end else if (enable) begin
                if (count == WIDTH'(1)) begin
                    count_n = '0;
                    done_n  = 1'b1;
                    state_n = auto_reload ? RUN : DONE;
                end else begin
                    count_n = (count == '0) ? reload_reg : count - WIDTH'(1);
                end
            end
        end
    end
    assign running = (state == RUN);
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed vectors with a scoreboard queue checked by a per-cycle monitor
module tb_countdown_timer;
    localparam int W = 3;
    logic         Clock = 1'b0;
    logic         reset = 1'b1, load = 1'b0, enable = 1'b0, auto_reload = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] count;
    logic         running, done;
    logic [W+1:0] exp_q[$];
    logic [W+1:0] e;
    int           checks = 0, failures = 0;

    countdown_timer #(.WIDTH(W)) dut (
        .Clock(Clock), .reset(reset), .load(load), .load_value(load_value),
        .enable(enable), .auto_reload(auto_reload),
        .count(count), .running(running), .done(done)
    );

    always #5 Clock = ~Clock;

    // monitor: after each edge, pop the expectation issued for that edge and compare
    always @(posedge Clock) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({count, running, done} !== e) begin
                failures++;
                $display("FAIL cycle check @%0t: got count=%0d running=%0b done=%0b, expected count=%0d running=%0b done=%0b",
                         $time, count, running, done, e[W+1:2], e[1], e[0]);
            end
        end
    end

    task automatic step(input logic r, input logic l, input logic [W-1:0] v, input logic en,
                        input logic ar, input logic [W-1:0] ec, input logic er, input logic ed);
        @(negedge Clock);
        reset = r; load = l; load_value = v; enable = en; auto_reload = ar;
        exp_q.push_back({ec, er, ed});
    endtask

    task automatic tick(input logic en, input logic ar, input logic [W-1:0] ec, input logic er, input logic ed);
        step(1'b0, 1'b0, W'(0), en, ar, ec, er, ed);
    endtask

    task automatic ld(input logic [W-1:0] v, input logic en, input logic ar,
                      input logic [W-1:0] ec, input logic er, input logic ed);
        step(1'b0, 1'b1, v, en, ar, ec, er, ed);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset, with load asserted to show reset wins, then hold idle
        step(1'b1, 1'b1, W'(5), 1'b1, 1'b0, W'(0), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, W'(0), 1'b0, 1'b0);
        // one-shot from 5
        ld(W'(5), 1'b1, 1'b0, W'(5), 1'b1, 1'b0);
        for (int i = 4; i >= 1; i--) tick(1'b1, 1'b0, W'(i), 1'b1, 1'b0);
        tick(1'b1, 1'b0, W'(0), 1'b0, 1'b1);
        tick(1'b1, 1'b0, W'(0), 1'b0, 1'b0);
        tick(1'b1, 1'b0, W'(0), 1'b0, 1'b0);
        // periodic from 3: period of 4 enabled cycles
        ld(W'(3), 1'b1, 1'b1, W'(3), 1'b1, 1'b0);
        for (int p = 0; p < 2; p++) begin
            tick(1'b1, 1'b1, W'(2), 1'b1, 1'b0);
            tick(1'b1, 1'b1, W'(1), 1'b1, 1'b0);
            tick(1'b1, 1'b1, W'(0), 1'b1, 1'b1);
            tick(1'b1, 1'b1, W'(3), 1'b1, 1'b0);
        end
        // max value 7 with pause
        ld(W'(7), 1'b1, 1'b0, W'(7), 1'b1, 1'b0);
        tick(1'b1, 1'b0, W'(6), 1'b1, 1'b0);
        tick(1'b0, 1'b0, W'(6), 1'b1, 1'b0);
        tick(1'b0, 1'b0, W'(6), 1'b1, 1'b0);
        tick(1'b1, 1'b0, W'(5), 1'b1, 1'b0);
        // run down to 2, then reload mid-run with enable high, then load 0
        tick(1'b1, 1'b0, W'(4), 1'b1, 1'b0);
        tick(1'b1, 1'b0, W'(3), 1'b1, 1'b0);
        tick(1'b1, 1'b0, W'(2), 1'b1, 1'b0);
        ld(W'(6), 1'b1, 1'b0, W'(6), 1'b1, 1'b0);
        ld(W'(0), 1'b1, 1'b0, W'(0), 1'b0, 1'b0);
        tick(1'b1, 1'b0, W'(0), 1'b0, 1'b0);
        tick(1'b1, 1'b1, W'(0), 1'b0, 1'b0);
        // auto_reload dropped while sitting at 0 in RUN
        ld(W'(1), 1'b1, 1'b1, W'(1), 1'b1, 1'b0);
        tick(1'b1, 1'b1, W'(0), 1'b1, 1'b1);
        tick(1'b0, 1'b0, W'(0), 1'b0, 1'b0);
        tick(1'b1, 1'b1, W'(0), 1'b0, 1'b0);
        // reset mid-run at count 4
        ld(W'(5), 1'b1, 1'b0, W'(5), 1'b1, 1'b0);
        tick(1'b1, 1'b0, W'(4), 1'b1, 1'b0);
        step(1'b1, 1'b0, W'(0), 1'b1, 1'b0, W'(0), 1'b0, 1'b0);
        tick(1'b1, 1'b0, W'(0), 1'b0, 1'b0);
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
